// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: instruction constants, fault causes, FSM states.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_FAULT_NONE     = 2'b00,
    FETCH_FAULT_MISALIGN = 2'b01,
    FETCH_FAULT_RANGE    = 2'b10
  } fetch_fault_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: redirect/stall/imem inputs and IF register / fault outputs.
interface instr_fetch_unit_if;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        stall_i;
  logic [31:0] instr_i;
  logic        imem_error_i;
  logic [31:0] pc_o;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_pc_plus4_o;
  logic [31:0] if_instr_o;
  logic        fault_o;
  logic [1:0]  fault_cause_o;
  logic [31:0] fault_pc_o;
  logic [31:0] fetch_count_o;

  // Fetch unit side
  modport master (
    input  redirect_valid_i, redirect_pc_i, stall_i, instr_i, imem_error_i,
    output pc_o, if_valid_o, if_pc_o, if_pc_plus4_o, if_instr_o,
           fault_o, fault_cause_o, fault_pc_o, fetch_count_o
  );

  // Memory / decode / branch-unit side
  modport slave (
    output redirect_valid_i, redirect_pc_i, stall_i, instr_i, imem_error_i,
    input  pc_o, if_valid_o, if_pc_o, if_pc_plus4_o, if_instr_o,
           fault_o, fault_cause_o, fault_pc_o, fetch_count_o
  );
endinterface

// File: rtl/fetch_next_pc.sv
// Priority mux for the fetch stage: misaligned redirect > redirect > stall > range error > sequential.
module fetch_next_pc
  import riscv_pkg::*;
(
  input  logic [31:0]  pc_i,
  input  logic         redirect_valid_i,
  input  logic [31:0]  redirect_pc_i,
  input  logic         stall_i,
  input  logic         range_err_i,
  output logic [31:0]  next_pc_o,
  output logic         capture_o,
  output logic         hold_o,
  output fetch_fault_e fault_cause_o,
  output logic [31:0]  fault_addr_o
);

  // Select the single action taken this cycle; a redirect masks stall and range errors.
  always_comb begin
    next_pc_o     = pc_i;
    capture_o     = 1'b0;
    hold_o        = 1'b0;
    fault_cause_o = FETCH_FAULT_NONE;
    fault_addr_o  = pc_i;
    if (redirect_valid_i && (redirect_pc_i[1:0] != 2'b00)) begin
      fault_cause_o = FETCH_FAULT_MISALIGN;
      fault_addr_o  = redirect_pc_i;
    end else if (redirect_valid_i) begin
      next_pc_o = redirect_pc_i;
    end else if (stall_i) begin
      hold_o = 1'b1;
    end else if (range_err_i) begin
      fault_cause_o = FETCH_FAULT_RANGE;
    end else begin
      capture_o = 1'b1;
      next_pc_o = pc_i + 32'd4;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, IF register, fetch counter and RUN/HALT fault FSM.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          IMEM_BYTES = 1024
) (
  input  logic               clk_i,
  input  logic               rst_i,
  instr_fetch_unit_if.master bus
);

  localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic         if_valid_q;
  logic [31:0]  if_pc_q;
  logic [31:0]  if_pc_plus4_q;
  logic [31:0]  if_instr_q;
  logic         fault_q;
  logic [1:0]   fault_cause_q;
  logic [31:0]  fault_pc_q;
  logic [31:0]  fetch_count_q;

  logic         range_err;
  logic [31:0]  pc_d;
  logic         capture_d;
  logic         hold_d;
  fetch_fault_e fault_cause_d;
  logic [31:0]  fault_pc_d;

  // Out-of-range fetch: memory flags it, or the PC is past the last word.
  assign range_err = bus.imem_error_i || (pc_q > LAST_PC);

  fetch_next_pc u_next_pc (
    .pc_i             (pc_q),
    .redirect_valid_i (bus.redirect_valid_i),
    .redirect_pc_i    (bus.redirect_pc_i),
    .stall_i          (bus.stall_i),
    .range_err_i      (range_err),
    .next_pc_o        (pc_d),
    .capture_o        (capture_d),
    .hold_o           (hold_d),
    .fault_cause_o    (fault_cause_d),
    .fault_addr_o     (fault_pc_d)
  );

  // RUN/HALT FSM with PC, IF register, counter and sticky fault state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      if_valid_q    <= 1'b0;
      if_pc_q       <= 32'h0000_0000;
      if_pc_plus4_q <= 32'h0000_0004;
      if_instr_q    <= NOP_INSTR;
      fault_q       <= 1'b0;
      fault_cause_q <= FETCH_FAULT_NONE;
      fault_pc_q    <= 32'h0000_0000;
      fetch_count_q <= 32'h0000_0000;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (fault_cause_d != FETCH_FAULT_NONE) begin
            state_q       <= ST_HALT;
            fault_q       <= 1'b1;
            fault_cause_q <= fault_cause_d;
            fault_pc_q    <= fault_pc_d;
            if_valid_q    <= 1'b0;
          end else begin
            pc_q <= pc_d;
            if (capture_d) begin
              if_valid_q    <= 1'b1;
              if_pc_q       <= pc_q;
              if_pc_plus4_q <= pc_q + 32'd4;
              if_instr_q    <= bus.instr_i;
              fetch_count_q <= fetch_count_q + 32'd1;
            end else if (!hold_d) begin
              if_valid_q <= 1'b0;
            end
          end
        end
        ST_HALT: begin
          if_valid_q <= 1'b0;
        end
        default: begin
          state_q <= ST_HALT;
        end
      endcase
    end
  end

  assign bus.pc_o          = pc_q;
  assign bus.if_valid_o    = if_valid_q;
  assign bus.if_pc_o       = if_pc_q;
  assign bus.if_pc_plus4_o = if_pc_plus4_q;
  assign bus.if_instr_o    = if_instr_q;
  assign bus.fault_o       = fault_q;
  assign bus.fault_cause_o = fault_cause_q;
  assign bus.fault_pc_o    = fault_pc_q;
  assign bus.fetch_count_o = fetch_count_q;

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage sitting directly upstream of the instruction memory. It owns the program counter, drives the memory's byte-address input, and captures the returned 32-bit instruction into an IF register with a valid/stall handshake toward decode. It also accepts branch/jump redirects and detects fetch faults: a misaligned target or an out-of-range memory access. On a fault it halts fetching until reset.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- IMEM_BYTES, 1024: instruction memory size in bytes; the last legal fetch PC is IMEM_BYTES-4.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- redirect_valid_i  in  1  taken branch/jump this cycle.
- redirect_pc_i  in  32  redirect target byte address.
- stall_i  in  1  decode not ready; hold the IF register and PC.
- instr_i  in  32  instruction word from the instruction memory for pc_o (combinational return).
- imem_error_i  in  1  memory range error for pc_o.
- pc_o  out  32  current fetch PC to the instruction memory.
- if_valid_o  out  1  IF register holds a valid instruction.
- if_pc_o  out  32  PC of the IF instruction.
- if_pc_plus4_o  out  32  if_pc_o + 4, modulo 2^32.
- if_instr_o  out  32  captured instruction.
- fault_o  out  1  sticky fault; fetch halted.
- fault_cause_o  out  2  00 none, 01 misaligned redirect, 10 memory range.
- fault_pc_o  out  32  offending address.
- fetch_count_o  out  32  instructions accepted into the IF register, wrapping.

## Operation
- FSM has two states, RUN and HALT. Reset enters RUN. Any fault moves RUN to HALT. HALT is left only by reset.
- Range error: imem_error_i is 1, or pc_o > IMEM_BYTES-4.
- Priority in RUN each cycle, highest first:
  1. redirect_valid_i with redirect_pc_i[1:0] != 0: go to HALT; cause 01; fault_pc = redirect_pc_i; pc_o unchanged; if_valid_o <= 0.
  2. redirect_valid_i, aligned target: pc_o <= redirect_pc_i; if_valid_o <= 0 (one-cycle bubble). A stall or range error in the same cycle is ignored.
  3. stall_i: pc_o, IF register and counter all hold.
  4. Range error: go to HALT; cause 10; fault_pc = pc_o; if_valid_o <= 0.
  5. Normal: IF register <= {pc_o, pc_o+4, instr_i}; if_valid_o <= 1; pc_o <= pc_o+4; fetch_count_o increments.
- In HALT: all inputs are ignored; pc_o and IF fields hold; if_valid_o = 0; fault outputs stay stable.
- PC arithmetic is 32-bit unsigned and wraps modulo 2^32. Wrap is unreachable in practice because the range check fires first.

## Timing
- Reset values:
  - pc_o = RESET_PC
  - if_valid_o = 0
  - if_pc_o = 0
  - if_pc_plus4_o = 4
  - if_instr_o = 32'h0000_0013 (NOP)
  - fault_o = 0, fault_cause_o = 00, fault_pc_o = 0
  - fetch_count_o = 0
- pc_o is registered. instr_i is sampled in the same cycle and appears on if_instr_o one edge later, so fetch latency is 1 cycle.
- Redirect takes effect at the next edge. The first instruction from the target is valid 2 edges after the redirect cycle.
- Stall has no bubble and no loss: the held instruction is presented again until stall_i drops.
- Asserting rst_i mid-operation clears all state immediately, including a sticky fault.
- fault_o and cause assert at the edge following the faulting cycle.

## Structure
- Shared package riscv_pkg holds:
  - NOP_INSTR = 32'h0000_0013
  - fault cause encodings FETCH_FAULT_NONE, FETCH_FAULT_MISALIGN, FETCH_FAULT_RANGE
  - DEFAULT_RESET_PC
- One sub-module, fetch_next_pc: a combinational priority mux that produces next PC, capture enable and fault cause from the redirect, stall and range inputs.
- The top level holds the FSM, PC register, IF register and counter.

## Test plan
- Reset, then 4 unstalled cycles, with the memory returning 0x12308093, 0x00208133, …: pc_o goes 0, 4, 8, C; if_instr_o lags by one cycle; fetch_count_o = 4.
- stall_i high for 3 cycles at pc_o = 8: pc_o stays 8; if_instr_o holds 0x00208133; counter is frozen; fetch resumes at 8 with no duplicate and no skip.
- Redirect to 0x30 together with stall_i = 1: next cycle pc_o = 0x30 and if_valid_o = 0; the cycle after, if_pc_o = 0x30 and if_valid_o = 1.
- Redirect to 0x22: fault_o = 1, cause = 01, fault_pc_o = 0x22; pc_o is unchanged; if_valid_o stays 0 for 5 further cycles regardless of inputs.
- Sequential run to pc_o = 0x3FC, then the step to 0x400: 0x3FC is captured normally; at 0x400, fault cause = 10 and fault_pc_o = 0x400. Also force imem_error_i = 1 at 0x10: cause 10.
- Assert rst_i asynchronously in HALT between edges: all outputs immediately return to their reset values, and fetch restarts at RESET_PC.
